// File: rtl/display_buffer_write_port.sv
// Avalon-MM write port that pairs each pushed pixel word with an address pointer
// and drains the pairs to the LED tile display buffer through a small FIFO.
module display_buffer_write_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [DATA_W-1:0] buf_data,
    output logic              buf_valid,
    input  logic              buf_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_ADDR   = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level;
    logic [ADDR_W-1:0] addr_ptr;
    logic [DATA_W-1:0] last_data;
    logic              autoinc;
    logic              overflow;

    logic wr_en, push_req, push_ok, push_rej, pop, flush;
    logic addr_wr, ctrl_wr, status_wr;
    logic full, empty;

    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);

    assign wr_en     = chipselect && !write_n;
    assign push_req  = wr_en && (address == REG_DATA);
    assign addr_wr   = wr_en && (address == REG_ADDR);
    assign ctrl_wr   = wr_en && (address == REG_CTRL);
    assign status_wr = wr_en && (address == REG_STATUS);
    assign flush     = ctrl_wr && writedata[1];

    // Fullness is judged on the registered level, so a same-cycle pop never frees a slot.
    assign push_ok  = push_req && !full;
    assign push_rej = push_req && full;
    assign pop      = buf_valid && buf_ready;

    assign buf_valid = !empty;
    assign buf_addr  = mem[rd_ptr].addr;
    assign buf_data  = mem[rd_ptr].data;

    always_comb begin
        // NOTE: default first so every path assigns readdata and no latch is inferred.
        readdata = '0;
        case (address)
            REG_DATA:   readdata = 32'(last_data);
            REG_ADDR:   readdata = 32'(addr_ptr);
            REG_CTRL:   readdata[0] = autoinc;
            REG_STATUS: begin
                readdata[8:0] = 9'(level);
                readdata[16]  = empty;
                readdata[17]  = full;
                readdata[31]  = overflow;
            end
            default:    readdata = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            addr_ptr  <= '0;
            last_data <= '0;
            autoinc   <= 1'b0;
            overflow  <= 1'b0;
            // NOTE: the array is reset too so the head outputs read zero after reset;
            // a plain RAM could not do this, but the storage here is a register array.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= '{addr: addr_ptr, data: writedata[DATA_W-1:0]};
                wr_ptr      <= wr_ptr + PTR_W'(1);
                last_data   <= writedata[DATA_W-1:0];
                if (autoinc) begin
                    addr_ptr <= addr_ptr + ADDR_W'(1);
                end
            end

            if (addr_wr) begin
                addr_ptr <= writedata[ADDR_W-1:0];
            end

            if (ctrl_wr) begin
                autoinc <= writedata[0];
            end

            if (push_rej) begin
                overflow <= 1'b1;
            end else if (status_wr && writedata[31]) begin
                overflow <= 1'b0;
            end

            // Flush and push target different registers, so wr_ptr is stable during a flush.
            if (flush) begin
                rd_ptr <= wr_ptr;
                level  <= '0;
            end else begin
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push_ok, pop})
                    2'b10:   level <= level + LVL_W'(1);
                    2'b01:   level <= level - LVL_W'(1);
                    default: level <= level;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_display_buffer_write_port.sv
// Directed self-checking bench for display_buffer_write_port (DEPTH=8, ADDR_W=10).
module tb_display_buffer_write_port;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [1:0]        address = 2'd0;
    logic              chipselect = 1'b0;
    logic              write_n = 1'b1;
    logic [31:0]       writedata = '0;
    logic [31:0]       readdata;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;
    logic              buf_valid;
    logic              buf_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    display_buffer_write_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .buf_addr   (buf_addr),
        .buf_data   (buf_data),
        .buf_valid  (buf_valid),
        .buf_ready  (buf_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] expected, input string tag);
        @(negedge clk);
        address = a;
        #1;
        check(tag, readdata, expected);
    endtask

    task automatic head(input logic [ADDR_W-1:0] ea, input logic [DATA_W-1:0] ed, input string tag);
        check({tag, "_valid"}, 32'(buf_valid), 32'd1);
        check({tag, "_addr"}, 32'(buf_addr), 32'(ea));
        check({tag, "_data"}, 32'(buf_data), 32'(ed));
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        rd(2'd3, 32'h0001_0000, "rst_status");
        rd(2'd1, 32'h0000_0000, "rst_addr");
        rd(2'd2, 32'h0000_0000, "rst_ctrl");
        rd(2'd0, 32'h0000_0000, "rst_data");
        check("rst_valid", 32'(buf_valid), 32'd0);

        // Autoinc across the top of the address space
        wr(2'd2, 32'h1);
        wr(2'd1, 32'h3FE);
        wr(2'd0, 32'hA);
        wr(2'd0, 32'hB);
        wr(2'd0, 32'hC);
        rd(2'd3, 32'h0000_0003, "lvl3_status");
        rd(2'd1, 32'h0000_0001, "lvl3_addr");
        rd(2'd0, 32'h0000_000C, "lvl3_data");
        rd(2'd2, 32'h0000_0001, "lvl3_ctrl");
        head(10'h3FE, 32'hA, "drain0");
        buf_ready = 1'b1;
        @(negedge clk); #1;
        head(10'h3FF, 32'hB, "drain1");
        @(negedge clk); #1;
        head(10'h000, 32'hC, "drain2");
        @(negedge clk); #1;
        check("drain_empty", 32'(buf_valid), 32'd0);
        buf_ready = 1'b0;

        // Fill past capacity: 9 writes, only 8 accepted
        for (int i = 0; i < DEPTH + 1; i++) begin
            wr(2'd0, 32'h100 + 32'(i));
        end
        rd(2'd3, 32'h8002_0008, "full_status");
        rd(2'd1, 32'h0000_0009, "full_addr");
        rd(2'd0, 32'h0000_0107, "full_data");
        head(10'h001, 32'h100, "full_head");
        wr(2'd3, 32'h8000_0000);
        rd(2'd3, 32'h0002_0008, "ovf_clear");

        // Push while full with a same-cycle pop is still rejected
        @(negedge clk);
        buf_ready  = 1'b1;
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 2'd0;
        writedata  = 32'h55;
        @(posedge clk); #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        buf_ready  = 1'b0;
        rd(2'd3, 32'h8000_0007, "rej_status");
        rd(2'd0, 32'h0000_0107, "rej_data");
        rd(2'd1, 32'h0000_0009, "rej_addr");
        head(10'h002, 32'h101, "rej_head");

        // Drain to one entry, then push and pop together
        @(negedge clk);
        buf_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        buf_ready = 1'b0;
        rd(2'd3, 32'h8000_0001, "one_status");
        head(10'h008, 32'h107, "one_head");
        @(negedge clk);
        buf_ready  = 1'b1;
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 2'd0;
        writedata  = 32'h66;
        @(posedge clk); #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        buf_ready  = 1'b0;
        rd(2'd3, 32'h8000_0001, "pushpop_status");
        head(10'h009, 32'h66, "pushpop_head");
        rd(2'd1, 32'h0000_000A, "pushpop_addr");
        wr(2'd3, 32'h8000_0000);

        // Flush during an active pop
        wr(2'd0, 32'h77);
        wr(2'd0, 32'h88);
        rd(2'd3, 32'h0000_0003, "preflush_status");
        @(negedge clk);
        buf_ready  = 1'b1;
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 2'd2;
        writedata  = 32'h3;
        @(posedge clk); #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        check("flush_valid", 32'(buf_valid), 32'd0);
        buf_ready = 1'b0;
        rd(2'd3, 32'h0001_0000, "flush_status");
        rd(2'd2, 32'h0000_0001, "flush_ctrl");
        rd(2'd1, 32'h0000_000C, "flush_addr");

        // Autoinc off leaves the pointer in place
        wr(2'd2, 32'h0);
        wr(2'd0, 32'h99);
        rd(2'd1, 32'h0000_000C, "noinc_addr");
        head(10'h00C, 32'h99, "noinc_head");

        // Reset mid-drain
        wr(2'd2, 32'h1);
        wr(2'd0, 32'h1);
        wr(2'd0, 32'h2);
        rd(2'd3, 32'h0000_0003, "predrain_status");
        @(negedge clk);
        buf_ready = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("mrst_valid", 32'(buf_valid), 32'd0);
        rd(2'd3, 32'h0001_0000, "mrst_status");
        rd(2'd1, 32'h0000_0000, "mrst_addr");
        rd(2'd2, 32'h0000_0000, "mrst_ctrl");
        rd(2'd0, 32'h0000_0000, "mrst_data");
        repeat (3) @(negedge clk);
        #1;
        check("mrst_quiet_valid", 32'(buf_valid), 32'd0);
        rd(2'd3, 32'h0001_0000, "mrst_quiet_status");
        buf_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_buffer_write_port.md
# display_buffer_write_port

Parametrised Avalon-MM write port that feeds pixel data into the LED tile display buffer. It is the successor to the single-register display-buffer data PIO. Software writes an address pointer and a stream of data words. Each data write is paired with the current pointer and queued in a small FIFO, and the FIFO drains into the display buffer over a valid/ready handshake. The block adds address auto-increment, flush, level/full/empty status and a sticky overflow flag.

## Interface
- DATA_W, 32, width of one pixel data word (1..32)
- ADDR_W, 10, display buffer address width (1..16)
- DEPTH, 8, FIFO entries; power of two, 2..256
- clk  in  1  system clock
- reset_n  in  1  reset; synchronous and active-low
- address  in  2  register select: 0 DATA, 1 ADDR, 2 CTRL, 3 STATUS
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe; a write occurs when chipselect && !write_n
- writedata  in  32  write data
- readdata  out  32  read data: combinational mux of registered state, zero wait states
- buf_addr  out  ADDR_W  address of the FIFO head entry
- buf_data  out  DATA_W  data of the FIFO head entry
- buf_valid  out  1  FIFO non-empty
- buf_ready  in  1  downstream accepts the head entry when high with buf_valid

## Operation
- Register map:
  - DATA (0), write: push {addr_ptr, writedata[DATA_W-1:0]}. Read: last pushed data, zero-extended.
  - ADDR (1), write: addr_ptr <= writedata[ADDR_W-1:0]. Read: addr_ptr.
  - CTRL (2): bit0 autoinc, read/write. Bit1 flush: write-1 action, self-clearing, reads 0. Other bits read 0.
  - STATUS (3), read only: [8:0] level, [16] empty, [17] full, [31] overflow. A write with writedata[31]=1 clears overflow; all other bits of the write are ignored.
- Push acceptance:
  - A push is accepted only when full=0 at the start of the cycle. A simultaneous pop does not make room for it.
  - Accepted push with autoinc=1: addr_ptr <= addr_ptr+1 modulo 2^ADDR_W, so 2^ADDR_W-1 wraps to 0.
  - Rejected push (FIFO full): data is dropped, overflow <= 1, addr_ptr unchanged, the DATA readback register unchanged.
- Pop occurs when buf_valid && buf_ready. The read pointer advances and the head outputs present the next entry.
- Simultaneous accepted push and pop leave level unchanged.
- Flush: FIFO is empty the next cycle (level 0, buf_valid 0) even if a pop coincides. addr_ptr, CTRL and overflow are unchanged.
- Level is a counter of width clog2(DEPTH)+1. Read and write pointers wrap modulo DEPTH.
- Storage is a register array of DEPTH x (ADDR_W+DATA_W). The head is read combinationally from the array at the read pointer.
- buf_addr and buf_data are don't-care when buf_valid=0. The bench must not check them then.

## Timing
- Reset (reset_n low at a clk edge), applied in the same edge:
  - addr_ptr, DATA readback, CTRL, overflow, level, both pointers -> 0.
  - Outputs: buf_valid=0, buf_addr=0, buf_data=0 (array entry 0 is also reset), readdata follows register state with STATUS=0x0001_0000.
  - Reset during a drain discards all queued entries.
- Push latency: a DATA write at edge N makes buf_valid high after edge N and updates level/empty at edge N.
- Pop latency: a pop at edge N updates head, level and buf_valid after edge N.
- Throughput: one push and one pop per cycle. readdata reflects state after the last edge in the same cycle.
- buf_valid never drops without a pop, flush or reset. Downstream may hold buf_ready low indefinitely.

## Test plan
- Reset, then read STATUS -> 0x0001_0000. Read ADDR -> 0. buf_valid=0.
- CTRL=1, ADDR=0x3FE, DATA writes 0xA, 0xB, 0xC with buf_ready=0 -> STATUS level=3. Then buf_ready=1 -> head sequence (0x3FE,0xA), (0x3FF,0xB), (0x000,0xC), then buf_valid=0. The third entry checks ADDR wrap-around.
- buf_ready=0, DEPTH+1 DATA writes with autoinc -> full=1, overflow=1, level=DEPTH. addr_ptr advanced by DEPTH only. Write 0x8000_0000 to STATUS -> overflow=0.
- FIFO full, buf_ready=1 and a DATA write in the same cycle -> push rejected (overflow=1), level=DEPTH-1 after. With one entry queued, simultaneous push and pop -> level stays 1.
- Three entries queued, write CTRL=0x3 during an active pop -> level=0 and buf_valid=0 next cycle. CTRL reads 0x1, addr_ptr unchanged.
- Assert reset_n low for one cycle mid-drain -> all registers and outputs return to their reset values, and no further pops occur.
